// File: rtl/resource_pool_lock.sv
`default_nettype none
// ============================================================================
// Module   : resource_pool_lock
// Purpose  : Lock responder that hands NUM_UNITS shared units to NUM_SICS
//            requesters, oldest issue_id first, held until release pulse.
// Revision : 1.0 - initial release
// ============================================================================
module resource_pool_lock #(
    parameter int NUM_SICS  = 4,
    parameter int NUM_UNITS = 1,
    parameter int ID_WIDTH  = 8,
    localparam int c_unit_w = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_SICS-1:0]            req,
    input  logic [NUM_SICS*ID_WIDTH-1:0]   req_issue_id,
    input  logic [NUM_SICS-1:0]            release_lock,
    output logic [NUM_SICS-1:0]            grant,
    output logic [NUM_SICS*c_unit_w-1:0]   grant_unit,
    output logic [NUM_UNITS-1:0]           unit_busy,
    output logic                           ignored_release
);

    localparam int c_sic_w = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1;

    logic [NUM_UNITS-1:0] r_owner_valid;
    logic [c_sic_w-1:0]   r_owner_sic [NUM_UNITS];
    logic                 r_ignored_release;

    logic [NUM_SICS-1:0]  w_owns;
    logic [c_unit_w-1:0]  w_owned_unit [NUM_SICS];
    logic [NUM_UNITS-1:0] w_rel_hit;
    logic [NUM_UNITS-1:0] w_free_after;
    logic [NUM_UNITS-1:0] w_free_onehot;
    logic [NUM_SICS-1:0]  w_eligible;
    logic                 w_win_valid;
    logic [c_sic_w-1:0]   w_win_sic;
    logic [ID_WIDTH-1:0]  w_win_id;
    logic                 w_grant_fire;
    logic [NUM_UNITS-1:0] w_valid_nxt;
    logic [c_sic_w-1:0]   w_sic_nxt [NUM_UNITS];

    // Modular age compare: a is older when (a - b) wraps into the upper half.
    function automatic logic is_older(input logic [ID_WIDTH-1:0] a,
                                      input logic [ID_WIDTH-1:0] b);
        logic [ID_WIDTH-1:0] diff;
        diff = a - b;
        return diff[ID_WIDTH-1];
    endfunction

    always_comb begin
        w_owns    = '0;
        w_rel_hit = '0;
        for (int s = 0; s < NUM_SICS; s++) begin
            w_owned_unit[s] = '0;
        end
        for (int s = 0; s < NUM_SICS; s++) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (r_owner_valid[u] && (r_owner_sic[u] == c_sic_w'(s))) begin
                    w_owns[s]       = 1'b1;
                    w_owned_unit[s] = c_unit_w'(u);
                    if (release_lock[s]) begin
                        w_rel_hit[u] = 1'b1;
                    end
                end
            end
        end
    end

    // Units released this edge are immediately reusable (same-edge handoff).
    assign w_free_after  = ~r_owner_valid | w_rel_hit;
    assign w_free_onehot = w_free_after & (~w_free_after + 1'b1);
    assign w_eligible    = req & ~w_owns & ~release_lock;

    always_comb begin
        w_win_valid = 1'b0;
        w_win_sic   = '0;
        w_win_id    = '0;
        // Strict compare keeps the lower index on equal ids.
        for (int s = 0; s < NUM_SICS; s++) begin
            if (w_eligible[s] &&
                (!w_win_valid || is_older(req_issue_id[s*ID_WIDTH +: ID_WIDTH], w_win_id))) begin
                w_win_valid = 1'b1;
                w_win_sic   = c_sic_w'(s);
                w_win_id    = req_issue_id[s*ID_WIDTH +: ID_WIDTH];
            end
        end
    end

    assign w_grant_fire = w_win_valid && (|w_free_after);

    always_comb begin
        w_valid_nxt = r_owner_valid & ~w_rel_hit;
        w_sic_nxt   = r_owner_sic;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (w_grant_fire && w_free_onehot[u]) begin
                w_valid_nxt[u] = 1'b1;
                w_sic_nxt[u]   = w_win_sic;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner_valid     <= '0;
            r_ignored_release <= 1'b0;
            for (int u = 0; u < NUM_UNITS; u++) begin
                r_owner_sic[u] <= '0;
            end
        end else begin
            r_owner_valid     <= w_valid_nxt;
            r_ignored_release <= |(release_lock & ~w_owns);
            for (int u = 0; u < NUM_UNITS; u++) begin
                r_owner_sic[u] <= w_sic_nxt[u];
            end
        end
    end

    // Outputs decode registered state only; nothing from req reaches them.
    always_comb begin
        grant_unit = '0;
        for (int s = 0; s < NUM_SICS; s++) begin
            grant_unit[s*c_unit_w +: c_unit_w] = w_owned_unit[s];
        end
    end

    assign grant           = w_owns;
    assign unit_busy       = r_owner_valid;
    assign ignored_release = r_ignored_release;

endmodule
`default_nettype wire

// File: tb/tb_resource_pool_lock.sv
`default_nettype none
// ============================================================================
// Module   : tb_resource_pool_lock
// Purpose  : Directed and random checks of resource_pool_lock with one and
//            two units against a queue-free ownership model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_resource_pool_lock;

    localparam int NS = 4;
    localparam int IW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NS-1:0]     req;
    logic [NS*IW-1:0]  req_issue_id;
    logic [NS-1:0]     release_lock;

    logic [NS-1:0] grant1, grant2;
    logic [NS-1:0] gu1, gu2;
    logic [0:0]    busy1;
    logic [1:0]    busy2;
    logic          ign1, ign2;

    resource_pool_lock #(.NUM_SICS(NS), .NUM_UNITS(1), .ID_WIDTH(IW)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_issue_id(req_issue_id),
        .release_lock(release_lock), .grant(grant1), .grant_unit(gu1),
        .unit_busy(busy1), .ignored_release(ign1)
    );

    resource_pool_lock #(.NUM_SICS(NS), .NUM_UNITS(2), .ID_WIDTH(IW)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_issue_id(req_issue_id),
        .release_lock(release_lock), .grant(grant2), .grant_unit(gu2),
        .unit_busy(busy2), .ignored_release(ign2)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // owner[k][u] = owning SIC of unit u in instance k, or -1 when free
    int owner [2][2];
    int nunits [2] = '{1, 2};
    bit m_ign [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int id_of(int s);
        return int'(req_issue_id[s*IW +: IW]);
    endfunction

    function automatic bit older(int a, int b);
        return (((a - b) % 256 + 256) % 256) >= 128;
    endfunction

    function automatic int unit_of(int k, int s);
        for (int u = 0; u < nunits[k]; u++) begin
            if (owner[k][u] == s) return u;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            owner[k][0] = -1;
            owner[k][1] = -1;
            m_ign[k]    = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int held [NS];
            int best;
            int fu;
            for (int s = 0; s < NS; s++) held[s] = unit_of(k, s);
            m_ign[k] = 1'b0;
            for (int s = 0; s < NS; s++) begin
                if (release_lock[s]) begin
                    if (held[s] >= 0) owner[k][held[s]] = -1;
                    else m_ign[k] = 1'b1;
                end
            end
            best = -1;
            for (int s = 0; s < NS; s++) begin
                if (req[s] && held[s] < 0 && !release_lock[s]) begin
                    if (best < 0 || older(id_of(s), id_of(best))) best = s;
                end
            end
            fu = -1;
            for (int u = nunits[k] - 1; u >= 0; u--) begin
                if (owner[k][u] < 0) fu = u;
            end
            if (best >= 0 && fu >= 0) owner[k][fu] = best;
        end
    endtask

    task automatic compare();
        logic [NS-1:0] eg [2];
        logic [NS-1:0] eu [2];
        logic [1:0]    eb [2];
        for (int k = 0; k < 2; k++) begin
            eg[k] = '0;
            eu[k] = '0;
            eb[k] = '0;
            for (int u = 0; u < nunits[k]; u++) begin
                if (owner[k][u] >= 0) begin
                    eb[k][u]           = 1'b1;
                    eg[k][owner[k][u]] = 1'b1;
                    eu[k][owner[k][u]] = (u == 1);
                end
            end
        end
        check("grant_u1", 32'(grant1), 32'(eg[0]));
        check("gunit_u1", 32'(gu1),    32'(eu[0]));
        check("busy_u1",  32'(busy1),  32'(eb[0][0]));
        check("ign_u1",   32'(ign1),   32'(m_ign[0]));
        check("grant_u2", 32'(grant2), 32'(eg[1]));
        check("gunit_u2", 32'(gu2),    32'(eu[1]));
        check("busy_u2",  32'(busy2),  32'(eb[1]));
        check("ign_u2",   32'(ign2),   32'(m_ign[1]));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        compare();
    endtask

    task automatic set_id(int s, int id);
        req_issue_id[s*IW +: IW] = IW'(id);
    endtask

    task automatic hard_reset();
        req          = '0;
        release_lock = '0;
        rst_n        = 1'b0;
        #2;
        model_reset();
        check("rst_grant", 32'({grant1, grant2}), 32'h0);
        check("rst_busy",  32'({busy1, busy2}),   32'h0);
        check("rst_ign",   32'({ign1, ign2}),     32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] base;
        rst_n        = 1'b0;
        req          = '0;
        release_lock = '0;
        req_issue_id = '0;
        model_reset();
        #12;
        compare();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // single requester: grant next cycle, held, freed by the release pulse
        req[0] = 1'b1; set_id(0, 5);
        step();
        check("t1_grant", 32'(grant1[0]), 32'd1);
        repeat (4) step();
        req[0] = 1'b0;
        step();
        check("t1_held", 32'(grant1[0]), 32'd1);
        release_lock[0] = 1'b1;
        step();
        release_lock[0] = 1'b0;
        check("t1_free", 32'({grant1, busy1}), 32'h0);

        // older id wins; released unit handed over with no idle cycle
        hard_reset();
        req[1] = 1'b1; set_id(1, 9);
        req[2] = 1'b1; set_id(2, 3);
        step();
        check("t2_first", 32'(grant1), 32'h4);
        req[2] = 1'b0;
        step();
        release_lock[2] = 1'b1;
        step();
        release_lock[2] = 1'b0;
        check("t2_handoff", 32'(grant1), 32'h2);

        // id wrap: 0xFE is older than 0x02
        hard_reset();
        req[0] = 1'b1; set_id(0, 8'h02);
        req[3] = 1'b1; set_id(3, 8'hFE);
        step();
        check("t3_wrap", 32'(grant1), 32'h8);

        // two units filled one per edge, freed unit reused by the waiter
        hard_reset();
        for (int s = 0; s < 3; s++) begin
            req[s] = 1'b1;
            set_id(s, s + 1);
        end
        step();
        check("t4_c1", 32'(grant2), 32'h1);
        step();
        check("t4_c2", 32'({grant2, gu2}), 32'h32);
        req[0] = 1'b0;
        step();
        release_lock[0] = 1'b1;
        step();
        release_lock[0] = 1'b0;
        check("t4_reuse", 32'({grant2, gu2}), 32'h62);

        // release from a non-owner only raises the debug pulse
        release_lock[3] = 1'b1;
        step();
        release_lock[3] = 1'b0;
        check("t5_ign", 32'({ign2, grant2}), 32'h16);
        step();
        check("t5_ign_low", 32'(ign2), 32'd0);

        // asynchronous reset while owning, then normal operation
        hard_reset();
        req[0] = 1'b1; set_id(0, 5);
        step();
        check("t6_own", 32'(grant1), 32'h1);
        rst_n = 1'b0;
        #2;
        check("t6_async", 32'({grant1, grant2, busy1, busy2}), 32'h0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        req = '0;
        release_lock[0] = 1'b1;
        step();
        release_lock[0] = 1'b0;
        check("t6_stale_rel", 32'(ign1), 32'd1);
        req[1] = 1'b1; set_id(1, 7);
        step();
        check("t6_regrant", 32'(grant1), 32'h2);

        // random traffic with ids kept inside a sliding window
        hard_reset();
        base = 8'hC0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            step();
            if (cyc == 300) begin
                hard_reset();
            end
            for (int s = 0; s < NS; s++) begin
                release_lock[s] = ($urandom_range(0, 9) == 0);
                if (req[s]) begin
                    if ($urandom_range(0, 7) == 0) req[s] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req[s] = 1'b1;
                    set_id(s, int'(base) + int'($urandom_range(0, 40)));
                end
            end
            if (cyc % 3 == 0) base = base + 8'd1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
